// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants, types and helpers for the register-bank write side.
//   NUM_REGS / REG_WIDTH / REG_ADDR_W : bank geometry (32 x 64, 5-bit index)
//   reg_addr_t / reg_word_t           : register index and register word
//   wr_state_t                        : write-side controller states
//   onehot_of()                       : 5-bit index to 32-bit one-hot
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_WIDTH  = 64;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_word_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } wr_state_t;

  // Plain one-hot expansion of a register index.
  function automatic logic [NUM_REGS-1:0] onehot_of(input reg_addr_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder5_32.sv
// ---------------------------------------------------------------------------
// decoder5_32
// 5-to-32 one-hot decoder with enable. With en=0 the output is all zero.
// Ports:
//   en     in   1   decode enable
//   addr   in   5   index to decode
//   onehot out  32  one-hot result, bit addr set when en=1
// ---------------------------------------------------------------------------
module decoder5_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] onehot
);

  // Enable gates the whole decode so a disabled decoder never selects a row.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write.sv
// ---------------------------------------------------------------------------
// regfile_write
// Write side of the 32 x 64-bit register bank. Accepts writes over a
// valid/ready handshake, performs a sequenced bulk clear (one register per
// cycle), and drives the flattened bank to the read-port multiplexers.
// Ports:
//   clk       in   1        clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   wr_valid  in   1        write request present
//   wr_ready  out  1        write can be accepted this cycle
//   wr_addr   in   5        destination register
//   wr_data   in   WIDTH    write data
//   clr_req   in   1        pulse requesting a bulk clear
//   busy      out  1        bulk clear in progress
//   regs      out  [NUM_REGS-1:0][WIDTH-1:0] packed bank, index = register
// Build option:
//   REGFILE_ZERO_REG_EN : register 31 becomes a hard-wired zero register
//                         (no storage, writes to it are discarded).
// ---------------------------------------------------------------------------
module regfile_write #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  regfile_pkg::reg_addr_t          wr_addr,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            clr_req,
  output logic                            busy,
  output logic [NUM_REGS-1:0][WIDTH-1:0]  regs
);

  import regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
  localparam int STORED_REGS = NUM_REGS - 1;
`else
  localparam int STORED_REGS = NUM_REGS;
`endif

  wr_state_t                        state;
  wr_state_t                        state_next;
  reg_addr_t                        clr_idx;
  logic                             wr_fire;
  logic [NUM_REGS-1:0]              wr_onehot;
  logic [NUM_REGS-1:0]              clr_onehot;
  logic [STORED_REGS-1:0][WIDTH-1:0] bank;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a clear request starts the sweep, and the sweep ends on
  // the edge that clears the last register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (clr_idx == reg_addr_t'(NUM_REGS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a clear request blocks writes in the same cycle so a write
  // can never race the first clear edge; the writer has to hold it.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    wr_ready = !clr_req;
      CLEAR:   busy     = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  // Clear index: loaded on entry, advanced every CLEAR cycle. The 5-bit
  // counter wraps 31 -> 0 exactly on the exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
    end else if (state == IDLE && clr_req) begin
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + reg_addr_t'(1);
    end
  end

  assign wr_fire = wr_valid && wr_ready;

  decoder5_32 u_wr_dec (
    .en     (wr_fire),
    .addr   (wr_addr),
    .onehot (wr_onehot)
  );

  assign clr_onehot = (state == CLEAR) ? onehot_of(clr_idx) : '0;

  // Register storage. Write and clear selects are never active together
  // (writes only in IDLE, clears only in CLEAR), so at most one row moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else begin
      for (int i = 0; i < STORED_REGS; i++) begin
        if (clr_onehot[i]) begin
          bank[i] <= '0;
        end else if (wr_onehot[i]) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

`ifdef REGFILE_ZERO_REG_EN
  assign regs = {{WIDTH{1'b0}}, bank};
`else
  assign regs = bank;
`endif

endmodule

// File: doc/regfile_write.md
# regfile_write

Write side of the 32 x 64-bit register bank in the processor datapath. Accepts write requests over a valid/ready handshake, decodes the 5-bit destination into a one-hot enable, and updates the addressed register. It also supports a sequenced bulk clear that zeroes the bank one register per cycle. It holds the register storage and drives the flattened bank to the read-port multiplexers.

## Interface

Parameters:
- NUM_REGS, 32, number of registers. Fixed to match the 5-bit address.
- WIDTH, 64, register width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- wr_valid  input  1  write request present
- wr_ready  output  1  block can accept a write this cycle
- wr_addr  input  5  destination register index
- wr_data  input  64  write data
- clr_req  input  1  single-cycle pulse requesting a bulk clear
- busy  output  1  bulk clear in progress
- regs  output  [31:0][63:0]  packed register bank, index = register number; feeds the read-mux DataIn

## Operation

- Reset: all registers are 0, state is IDLE and clr_idx is 0. Outputs are then wr_ready=1, busy=0 and regs=0.
- FSM states:
  - IDLE: wr_ready = !clr_req.
  - CLEAR: wr_ready = 0, busy = 1.
- Write:
  - A write is accepted when wr_valid && wr_ready at a rising edge.
  - regs[wr_addr] <= wr_data. All other registers hold their value.
- The one-hot enable is decoded from wr_addr and gated by the handshake. At most one register changes per cycle.
- IDLE -> CLEAR:
  - Taken on clr_req=1. clr_idx is loaded with 0.
  - A simultaneous wr_valid is not accepted because wr_ready=0. The writer must hold the request.
- CLEAR:
  - Each cycle: regs[clr_idx] <= 0, then clr_idx increments.
  - The state returns to IDLE on the edge that clears register 31.
  - clr_req is ignored while in CLEAR.
- clr_idx is 5 bits. It wraps from 31 to 0 only on exit from CLEAR and is never used in IDLE.
- Unaccepted requests: wr_valid=1 with wr_ready=0 has no effect. wr_addr and wr_data may change freely while wr_valid=0.
- Reset mid-clear: the bank is zeroed immediately, the state returns to IDLE and busy drops asynchronously.

## Timing

- Write latency: 1 cycle. The value is visible on regs after the accepting edge. There is no combinational path from wr_data to regs.
- Back-to-back writes are sustained at 1 per cycle in IDLE.
- Bulk clear: exactly 32 cycles with busy=1.
  - The first edge after clr_req enters CLEAR and clears nothing.
  - The 32 edges in CLEAR clear registers 0..31 in order.
  - busy falls and wr_ready rises in the cycle after register 31 is cleared.
- Combinational dependency: wr_ready depends on clr_req within the same cycle. busy is a registered state decode.

## Configuration

- Macro: REGFILE_ZERO_REG_EN.
- With the macro defined:
  - Register 31 is the architectural zero register.
  - regs[31] is constant 0 and has no storage.
  - Writes to address 31 complete the handshake normally but the data is discarded.
  - CLEAR still takes 32 cycles.
- Without the macro: register 31 is an ordinary writable register, identical to 0..30.

## Structure

- Package regfile_pkg holds:
  - Constants NUM_REGS=32, REG_WIDTH=64, REG_ADDR_W=5.
  - typedef reg_addr_t as logic [4:0].
  - typedef reg_word_t as logic [63:0].
  - enum wr_state_t {IDLE, CLEAR}.
- Sub-module decoder5_32: 5-to-32 one-hot decoder with an enable input. Enable=0 gives all-zero output.
- The top level instantiates the decoder once. The clear path uses a second decode of clr_idx.

## Test plan

- Write sequencing: reset, then write addr 3 = 0xDEADBEEF_00000001 and addr 4 = 0x1 on consecutive cycles.
  - One cycle after each accepting edge, regs[3] and regs[4] hold those values.
  - All other registers remain 0.
- Held write during clear:
  - Stimulus: fill all 32 registers with 0xFFFF_FFFF_FFFF_FFFF, pulse clr_req, and hold wr_valid with addr 7 = 0x55 throughout.
  - Response: busy is high for exactly 32 cycles and regs[k] clears on the k-th CLEAR edge.
  - The held write is accepted on the first cycle after busy falls, so regs[7] = 0x55 and all others are 0.
- Simultaneous request: clr_req and wr_valid (addr 2 = 0xAA) asserted in the same IDLE cycle.
  - wr_ready=0 in that cycle.
  - regs[2] is not written before the clear.
- Reset mid-clear: assert rst_n=0 at CLEAR cycle 10.
  - busy=0 and regs are all 0 immediately, without waiting for a clock edge.
  - After release, a write to addr 1 is accepted on the first edge.
- Address 31 write: write addr 31 = 0x1234.
  - With REGFILE_ZERO_REG_EN: the handshake completes and regs[31] stays 0.
  - Without it: regs[31] = 0x1234.
- Ignored request: wr_valid=0 with a random wr_addr and wr_data for 100 cycles leaves regs unchanged.
